// File: rtl/fc_pkg.sv
// Shared types and width helpers for the sequential fully-connected layer.
package fc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        FLUSH,
        EMIT
    } fc_state_t;

    // Accumulator width that holds IN full-scale signed products without overflow.
    function automatic int fc_acc_w(input int width, input int in_len);
        return 2 * width + $clog2(in_len);
    endfunction

endpackage

// File: rtl/fc_dot_lanes.sv
// Combinational signed dot product of one beat: LANES input elements times LANES weights.
module fc_dot_lanes #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    localparam int DOT_W = 2 * WIDTH + $clog2(LANES)
) (
    input  logic [LANES*WIDTH-1:0] x,
    input  logic [LANES*WIDTH-1:0] w,
    output logic signed [DOT_W-1:0] dot
);

    logic signed [2*WIDTH-1:0] prod;

    always_comb begin
        dot  = '0;
        prod = '0;
        for (int k = 0; k < LANES; k++) begin
            prod = $signed(x[k*WIDTH +: WIDTH]) * $signed(w[k*WIDTH +: WIDTH]);
            dot  = dot + DOT_W'(prod);
        end
    end

endmodule

// File: rtl/fc_seq_layer.sv
// Sequential fully-connected layer with ReLU: buffers one input vector, then emits one neuron per handshake.
// Optional macro FC_BIAS_EN adds the b_data port and initialises each neuron's accumulator with its bias.
module fc_seq_layer
    import fc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IN    = 128,
    parameter int OUT   = 10,
    parameter int LANES = 4,
    localparam int BEATS = IN / LANES,
`ifdef FC_BIAS_EN
    localparam int ACC_W = fc_acc_w(WIDTH, IN) + 1,
`else
    localparam int ACC_W = fc_acc_w(WIDTH, IN),
`endif
    localparam int AW = (OUT * BEATS > 1) ? $clog2(OUT * BEATS) : 1,
    localparam int IW = (OUT > 1) ? $clog2(OUT) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LANES*WIDTH-1:0] x_data,
    input  logic                   x_valid,
    output logic                   x_ready,
    output logic [AW-1:0]          w_addr,
    input  logic [LANES*WIDTH-1:0] w_data,
`ifdef FC_BIAS_EN
    input  logic [2*WIDTH-1:0]     b_data,
`endif
    output logic [ACC_W-1:0]       z,
    output logic [IW-1:0]          z_idx,
    output logic                   z_valid,
    input  logic                   z_ready,
    output logic                   busy
);

    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DOT_W = 2 * WIDTH + $clog2(LANES);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [IW-1:0] LAST_N    = IW'(OUT - 1);

    function automatic logic [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] a);
        return a[ACC_W-1] ? '0 : a;
    endfunction

    fc_state_t state, state_nx;

    logic [BW-1:0]          lbeat;
    logic [BW-1:0]          beat;
    logic [IW-1:0]          neuron;
    logic [LANES*WIDTH-1:0] xbuf [BEATS];
    logic                   x_fire;
    logic                   z_fire;

    logic                    vld_p1;
    logic                    first_p1;
    logic [BW-1:0]           beat_p1;
    logic signed [DOT_W-1:0] dot_p1;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_init;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        x_ready  = 1'b0;
        z_valid  = 1'b0;
        busy     = (state != IDLE);
        case (state)
            IDLE: begin
                x_ready = rst_n;
                if (x_valid) state_nx = (BEATS == 1) ? COMPUTE : LOAD;
            end
            LOAD: begin
                x_ready = rst_n;
                if (x_valid && lbeat == LAST_BEAT) state_nx = COMPUTE;
            end
            COMPUTE: begin
                if (beat == LAST_BEAT) state_nx = FLUSH;
            end
            FLUSH: state_nx = EMIT;
            EMIT: begin
                z_valid = 1'b1;
                if (z_ready) state_nx = (neuron == LAST_N) ? IDLE : COMPUTE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign x_fire = x_valid & x_ready;
    assign z_fire = z_valid & z_ready;
    assign w_addr = AW'(int'(neuron) * BEATS + int'(beat));
    assign z      = relu(acc);
    assign z_idx  = neuron;

`ifdef FC_BIAS_EN
    assign acc_init = ACC_W'($signed(b_data));
`else
    assign acc_init = '0;
`endif

    always_ff @(posedge clk) begin
        if (x_fire) xbuf[lbeat] <= x_data;
    end

    // p0: address issue; the weight for beat_p0 returns one cycle later as stage p1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lbeat    <= '0;
            beat     <= '0;
            neuron   <= '0;
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            acc      <= '0;
        end else begin
            if (x_fire) lbeat <= (lbeat == LAST_BEAT) ? '0 : lbeat + 1'b1;
            if (state == COMPUTE) beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
            if (z_fire) neuron <= (neuron == LAST_N) ? '0 : neuron + 1'b1;
            vld_p1   <= (state == COMPUTE);
            first_p1 <= (state == COMPUTE) && (beat == '0);
            if (vld_p1) acc <= (first_p1 ? acc_init : acc) + ACC_W'(dot_p1);
        end
    end

    always_ff @(posedge clk) begin
        beat_p1 <= beat;
    end

    // p1: weight data present, multiply against the buffered beat and accumulate
    fc_dot_lanes #(
        .WIDTH(WIDTH),
        .LANES(LANES)
    ) u_dot (
        .x   (xbuf[beat_p1]),
        .w   (w_data),
        .dot (dot_p1)
    );

endmodule

// File: tb/tb_fc_seq_layer.sv
// Self-checking bench for fc_seq_layer (WIDTH=8, IN=8, LANES=2, OUT=3) against a dot-product reference.
module tb_fc_seq_layer;

    localparam int WIDTH = 8;
    localparam int IN    = 8;
    localparam int OUT   = 3;
    localparam int LANES = 2;
    localparam int BEATS = IN / LANES;
    localparam int XW    = LANES * WIDTH;
`ifdef FC_BIAS_EN
    localparam int ACC_W = 20;
`else
    localparam int ACC_W = 19;
`endif
    localparam int AW = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [XW-1:0]    x_data;
    logic             x_valid;
    logic             x_ready;
    logic [AW-1:0]    w_addr;
    logic [XW-1:0]    w_data;
    logic [ACC_W-1:0] z;
    logic [IW-1:0]    z_idx;
    logic             z_valid;
    logic             z_ready;
    logic             busy;
`ifdef FC_BIAS_EN
    logic [2*WIDTH-1:0] b_data;
`endif

    int xe [IN];
    int we [OUT][IN];
    int bias [OUT];
    logic [XW-1:0] wmem [OUT*BEATS];

    int checks = 0;
    int errors = 0;

    fc_seq_layer #(.WIDTH(WIDTH), .IN(IN), .OUT(OUT), .LANES(LANES)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .x_data  (x_data),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .w_addr  (w_addr),
        .w_data  (w_data),
`ifdef FC_BIAS_EN
        .b_data  (b_data),
`endif
        .z       (z),
        .z_idx   (z_idx),
        .z_valid (z_valid),
        .z_ready (z_ready),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Weight/bias memory: one-cycle read latency
    always @(posedge clk) w_data <= wmem[w_addr];
`ifdef FC_BIAS_EN
    always @(posedge clk) b_data <= 16'(bias[int'(w_addr) / BEATS]);
`endif

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint model_z(input int n);
        longint s;
`ifdef FC_BIAS_EN
        s = longint'(bias[n]);
`else
        s = 0;
`endif
        for (int i = 0; i < IN; i++) s += longint'(xe[i]) * longint'(we[n][i]);
        return (s < 0) ? 0 : s;
    endfunction

    function automatic logic [XW-1:0] pack_x(input int b);
        logic [XW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*WIDTH +: WIDTH] = WIDTH'(xe[b*LANES+k]);
        return r;
    endfunction

    task automatic load_w();
        for (int n = 0; n < OUT; n++)
            for (int b = 0; b < BEATS; b++)
                for (int k = 0; k < LANES; k++)
                    wmem[n*BEATS+b][k*WIDTH +: WIDTH] = WIDTH'(we[n][b*LANES+k]);
    endtask

    task automatic fill(input int xv, input int wbase, input int wstep);
        for (int i = 0; i < IN; i++) xe[i] = xv;
        for (int n = 0; n < OUT; n++)
            for (int i = 0; i < IN; i++) we[n][i] = wbase + wstep * n;
        load_w();
    endtask

    task automatic rand_fill();
        for (int i = 0; i < IN; i++) xe[i] = int'($urandom_range(0, 255)) - 128;
        for (int n = 0; n < OUT; n++)
            for (int i = 0; i < IN; i++) we[n][i] = int'($urandom_range(0, 255)) - 128;
        load_w();
    endtask

    task automatic run_vector(input bit gaps, input bit noise, input int stall_n);
        int b;
        int k;
        int guard;
        logic [AW-1:0] ah;
        b = 0;
        guard = 0;
        while (b < BEATS && guard < 200) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(0, 1) == 0) begin
                x_valid = 1'b0;
                x_data  = XW'($urandom);
            end else begin
                x_valid = 1'b1;
                x_data  = pack_x(b);
                if (x_ready) b++;
            end
        end
        check("load_beats", 64'(b), 64'(BEATS));
        @(posedge clk);
        for (int n = 0; n < OUT; n++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
                z_ready = 1'b0;
                x_valid = noise;
                x_data  = XW'($urandom);
            end while (!z_valid && k < 50);
            check("latency", 64'(k), 64'(BEATS + 2));
            check("z", 64'(z), model_z(n));
            check("z_idx", 64'(z_idx), 64'(n));
            if (n == stall_n) begin
                ah = w_addr;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_z", 64'(z), model_z(n));
                    check("stall_idx", 64'(z_idx), 64'(n));
                    check("stall_valid", 64'(z_valid), 64'(1));
                    check("stall_xready", 64'(x_ready), 64'(0));
                    check("stall_waddr", 64'(w_addr), 64'(ah));
                end
            end
            z_ready = 1'b1;
        end
        @(negedge clk);
        z_ready = 1'b0;
        x_valid = 1'b0;
        check("idle_xready", 64'(x_ready), 64'(1));
        check("idle_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        int zv;
        rst_n   = 1'b0;
        x_valid = 1'b0;
        x_data  = '0;
        z_ready = 1'b0;
        for (int n = 0; n < OUT; n++) bias[n] = 0;
        fill(0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_zvalid", 64'(z_valid), 64'(0));
        check("rst_xready", 64'(x_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_waddr", 64'(w_addr), 64'(0));
        check("rst_z", 64'(z), 64'(0));
        check("rst_zidx", 64'(z_idx), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_xready", 64'(x_ready), 64'(1));

        fill(1, 1, 1);
        run_vector(1'b0, 1'b0, -1);
        fill(-128, -128, 0);
        run_vector(1'b0, 1'b0, -1);
        fill(-128, 127, 0);
        run_vector(1'b0, 1'b0, -1);

        rand_fill();
        run_vector(1'b0, 1'b0, 1);

        // Abort a vector after its second beat
        rand_fill();
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            x_valid = 1'b1;
            x_data  = pack_x(b);
        end
        @(negedge clk);
        x_valid = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 64'(busy), 64'(0));
        zv = 0;
        repeat (15) begin
            @(negedge clk);
            if (z_valid) zv++;
        end
        check("abort_no_zvalid", 64'(zv), 64'(0));
        rand_fill();
        run_vector(1'b0, 1'b0, -1);

        for (int r = 0; r < 4; r++) begin
            rand_fill();
            run_vector(1'b1, r[0], r);
        end

`ifdef FC_BIAS_EN
        fill(1, 1, 0);
        for (int n = 0; n < OUT; n++) bias[n] = -10;
        run_vector(1'b0, 1'b0, -1);
        for (int n = 0; n < OUT; n++) bias[n] = 10;
        run_vector(1'b0, 1'b0, -1);
        for (int n = 0; n < OUT; n++) bias[n] = int'($urandom_range(0, 2000)) - 1000;
        rand_fill();
        run_vector(1'b1, 1'b1, 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fc_seq_layer.md
FC_SEQ_LAYER -- requirements
Module: fc_seq_layer

Interface
REQ-001 Parameter WIDTH, default 8, signed input and weight element width.
REQ-002 Parameter IN, default 128, input vector length; SHALL be a multiple of LANES.
REQ-003 Parameter OUT, default 10, number of output neurons.
REQ-004 Parameter LANES, default 4, elements consumed per beat.
REQ-005 Derived: BEATS = IN/LANES; ACC_W = WIDTH*2+$clog2(IN) (+1 when FC_BIAS_EN is defined).
REQ-006 One clock; reset is synchronous and active-low. Ports: clk (in, 1, rising-edge clock) and rst_n (in, 1, synchronous active-low reset).
REQ-007 x_data  in  LANES*WIDTH  input beat; lane k occupies bits [k*WIDTH +: WIDTH] and is element beat*LANES+k.
REQ-008 x_valid  in  1; x_ready  out  1 — input beat handshake.
REQ-009 w_addr  out  $clog2(OUT*BEATS)  weight read address, value neuron*BEATS+beat.
REQ-010 w_data  in  LANES*WIDTH  signed weights, valid exactly one cycle after w_addr is issued.
REQ-011 b_data  in  WIDTH*2  signed bias for neuron w_addr/BEATS; present only with FC_BIAS_EN.
REQ-012 z  out  ACC_W  ReLU'd neuron result; z_idx  out  $clog2(OUT)  neuron index.
REQ-013 z_valid  out  1; z_ready  in  1 — output handshake.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, LOAD, COMPUTE, FLUSH, EMIT.
REQ-016 IDLE: x_ready=1. First accepted beat (x_valid&x_ready) is stored as beat 0 and moves the FSM to LOAD.
REQ-017 LOAD: x_ready=1. Each accepted beat is stored in the IN×WIDTH input buffer. Acceptance of beat BEATS-1 moves the FSM to COMPUTE with neuron=0 and beat=0. Gaps in x_valid stall LOAD.
REQ-018 COMPUTE: x_ready=0. One w_addr is issued per cycle, beat 0..BEATS-1. The accumulator is cleared (or loaded with bias) in the cycle beat 0's w_data arrives. Each w_data adds the sum of the LANES signed products with the buffered x elements.
REQ-019 After issuing beat BEATS-1, the FSM enters FLUSH for one cycle to absorb the last w_data, then EMIT.
REQ-020 EMIT: z_valid=1, z=max(acc,0), z_idx=neuron. z, z_idx and z_valid are held stable until z_ready.
REQ-021 On z_valid&z_ready: if neuron<OUT-1, increment neuron and return to COMPUTE; else go to IDLE.
REQ-022 Per-neuron latency is BEATS+2 cycles from COMPUTE entry to z_valid. A new input vector is accepted only after the final neuron handshake.
REQ-023 All multiply/add is two's-complement signed at ACC_W width with sign extension; no overflow can occur.
REQ-024 ReLU selects 0 when acc[ACC_W-1]=1; zero passes through as zero.
REQ-025 x_valid asserted while x_ready=0 SHALL be ignored, with no buffer change.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE and clear the counters and accumulator. Outputs: z=0, z_idx=0, z_valid=0, x_ready=0 during reset (1 from the first cycle after release), w_addr=0, busy=0.
REQ-027 Reset mid-LOAD or mid-COMPUTE discards the partial vector and results; no z_valid is produced for them.

Configuration
REQ-028 Macro FC_BIAS_EN defined: the accumulator initialises to sign-extended b_data (sampled with beat 0's w_data), and ACC_W gains 1 bit. Undefined: the b_data port is absent and the accumulator initialises to 0.

Structure
REQ-029 Package fc_pkg holds the state enum typedef and acc-width function fc_acc_w(WIDTH,IN).
REQ-030 One sub-module, fc_dot_lanes: combinational signed sum of LANES WIDTH×WIDTH products, output WIDTH*2+$clog2(LANES) bits.

Verification (WIDTH=8, IN=8, LANES=2, OUT=3 unless noted)
REQ-031 x=all 1, weights neuron n all (n+1) -> z=8,16,24 with z_idx 0,1,2; each z_valid comes 6 cycles after COMPUTE entry.
REQ-032 x=all -128, weights all -128 -> z=131072 with no overflow. Weights all +127 -> z=0 (ReLU).
REQ-033 z_ready held low 5 cycles on neuron 1 -> z and z_idx stable, no w_addr advance, no x_ready.
REQ-034 rst_n low for one cycle after the 2nd input beat -> no z_valid; the next full vector computes correctly.
REQ-035 x_valid toggling 1/0 during LOAD -> only handshaked beats stored; results match the reference model.
REQ-036 FC_BIAS_EN, bias=-10, x and w all 1 -> z=0. Bias=+10 -> z=18.
